// File: rtl/axis_snoop_pkg.sv
// Shared definitions for the snoop-FIFO drain arbiter.
//   arb_state_t         : arbiter FSM states
//   MAX_PKT_LEN_DEFAULT : default overlength threshold in beats
//   next_rr()           : round-robin search, used by the RTL picker and the bench model
package axis_snoop_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } arb_state_t;

  localparam int MAX_PKT_LEN_DEFAULT = 1500;
  localparam int RR_MAX_CH           = 32;

  // Returns the first set request found by searching from last+1 upward,
  // wrapping modulo num_ch. Returns -1 when no request is set.
  function automatic int next_rr(input logic [RR_MAX_CH-1:0] req,
                                 input int                   last,
                                 input int                   num_ch);
    int                   idx;
    logic [RR_MAX_CH-1:0] rot;
    next_rr = -1;
    for (int i = 1; i <= RR_MAX_CH; i++) begin
      if (i <= num_ch) begin
        idx = (last + i) % num_ch;
        rot = req >> idx;
        if (next_rr < 0 && rot[0]) next_rr = idx;
      end
    end
  endfunction

endpackage

// File: rtl/axis_snoop_rr_arbiter_if.sv
// Bus bundle for the drain arbiter: NUM_CH AXI-Stream inputs and the merged output.
//   slave  : arbiter view (consumes s_axis_*, produces m_axis_*)
//   master : environment view (drives s_axis_* and m_axis_tready)
interface axis_snoop_rr_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            s_axis_tvalid;
  logic [NUM_CH-1:0]            s_axis_tready;
  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]            s_axis_tlast;

  logic                         m_axis_tvalid;
  logic                         m_axis_tready;
  logic [DATA_WIDTH-1:0]        m_axis_tdata;
  logic                         m_axis_tlast;
  logic [CH_W-1:0]              m_axis_tdest;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest
  );
endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker.
//   req        : per-channel request vector
//   last_grant : channel served most recently
//   grant      : next channel to serve (0 when none requests)
//   grant_vld  : at least one channel requests
module axis_rr_pick
  import axis_snoop_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant,
  output logic              grant_vld
);

  logic [RR_MAX_CH-1:0] req_ext;
  int                   pick;

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_CH-1:0] = req;
    pick                = next_rr(req_ext, int'(last_grant), NUM_CH);
    grant_vld           = (pick >= 0);
    grant               = grant_vld ? pick[CH_W-1:0] : '0;
  end

endmodule

// File: rtl/axis_snoop_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_CH snoop FIFO outputs onto one stream.
//   s_axis_aclk    : clock
//   s_axis_areset  : asynchronous active-high reset
//   bus            : input channels and registered merged output (tdest = source)
//   pkt_count      : packets forwarded, wraps at 2^32
//   err_overlength : sticky, set when a packet exceeds MAX_PKT_LEN beats
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin, all tready low
// FWD   | granted channel owns the output until its tlast beat is accepted
module axis_snoop_rr_arbiter
  import axis_snoop_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEFAULT
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_areset,
  axis_snoop_rr_arbiter_if.slave  bus,
  output logic [31:0]             pkt_count,
  output logic                    err_overlength
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int BC_W = $clog2(MAX_PKT_LEN + 2);

  arb_state_t            state;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       last_grant;
  logic [CH_W-1:0]       pick_grant;
  logic                  pick_vld;
  logic [BC_W-1:0]       beat_cnt;

  logic                  out_free;
  logic                  in_hs;
  logic                  out_hs;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_CH-1:0]     ready_c;

  axis_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .req        (bus.s_axis_tvalid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_vld  (pick_vld)
  );

  // Output slot can take a beat when empty or being drained this cycle.
  assign out_free = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign out_hs   = bus.m_axis_tvalid && bus.m_axis_tready;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    ready_c  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == CH_W'(c)) begin
        sel_data = bus.s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        sel_last = bus.s_axis_tlast[c];
        ready_c[c] = (state == FWD) && out_free;
      end
    end
  end

  assign bus.s_axis_tready = ready_c;
  assign in_hs = |(ready_c & bus.s_axis_tvalid);

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state             <= IDLE;
      grant             <= '0;
      last_grant        <= CH_W'(NUM_CH - 1);
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tdest  <= '0;
      pkt_count         <= '0;
      err_overlength    <= 1'b0;
      beat_cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_grant;
            state <= FWD;
          end
        end
        FWD: begin
          // Grant is held until the owner's tlast beat, regardless of tvalid gaps.
          if (in_hs && sel_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
      endcase

      if (in_hs) begin
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tdata  <= sel_data;
        bus.m_axis_tlast  <= sel_last;
        bus.m_axis_tdest  <= grant;
      end else if (out_hs) begin
        bus.m_axis_tvalid <= 1'b0;
      end

      if (out_hs && bus.m_axis_tlast) pkt_count <= pkt_count + 32'd1;

      if (in_hs) begin
        if (sel_last) begin
          beat_cnt <= '0;
        end else if (beat_cnt < BC_W'(MAX_PKT_LEN + 1)) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        // This beat is number MAX_PKT_LEN and more follow: packet is overlength.
        if (!sel_last && beat_cnt == BC_W'(MAX_PKT_LEN - 1)) err_overlength <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_snoop_rr_arbiter.sv
module tb_axis_snoop_rr_arbiter;
  import axis_snoop_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int MAXL   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_count;
  logic        err;

  always #5 clk = ~clk;

  axis_snoop_rr_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  axis_snoop_rr_arbiter #(
    .NUM_CH      (NUM_CH),
    .DATA_WIDTH  (DW),
    .MAX_PKT_LEN (MAXL)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_areset  (rst),
    .bus            (bus.slave),
    .pkt_count      (pkt_count),
    .err_overlength (err)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] dest;
    logic       chk_err;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic push_beat(input int ch, input logic [7:0] d, input logic l,
                           input logic ce, input logic e);
    exp_t x;
    x.data = d; x.last = l; x.dest = 2'(ch); x.chk_err = ce; x.err = e;
    q.push_back(x);
  endtask

  task automatic push_pkt(input int ch, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) push_beat(ch, base + 8'(i), (i == len - 1), 1'b0, 1'b0);
  endtask

  task automatic send_beat(input int ch, input logic [7:0] d, input logic l);
    logic hs;
    int   t;
    hs = 1'b0;
    t  = 0;
    bus.s_axis_tvalid[ch]          = 1'b1;
    bus.s_axis_tdata[ch*DW +: DW]  = d;
    bus.s_axis_tlast[ch]           = l;
    while (!hs && t < 300) begin
      @(negedge clk);
      hs = bus.s_axis_tready[ch];
      @(posedge clk);
      #1;
      t++;
    end
    if (!hs) begin
      n_chk++;
      $display("FAIL hs_timeout ch%0d: no tready after %0d cycles, required within 300", ch, t);
    end
  endtask

  task automatic send_pkt(input int ch, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) send_beat(ch, base + 8'(i), (i == len - 1));
    bus.s_axis_tvalid[ch] = 1'b0;
    bus.s_axis_tlast[ch]  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on every output handshake; checks stability during stalls.
  logic       prev_stall = 1'b0;
  logic [7:0] sv_data;
  logic       sv_last;
  logic [1:0] sv_dest;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_axis_tvalid), 32'd1);
        check("stall_data",  32'(bus.m_axis_tdata),  32'(sv_data));
        check("stall_last",  32'(bus.m_axis_tlast),  32'(sv_last));
        check("stall_dest",  32'(bus.m_axis_tdest),  32'(sv_dest));
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_beat: got data %0h dest %0d, required no beat",
                   bus.m_axis_tdata, bus.m_axis_tdest);
        end else begin
          e = q.pop_front();
          check("out_data", 32'(bus.m_axis_tdata), 32'(e.data));
          check("out_last", 32'(bus.m_axis_tlast), 32'(e.last));
          check("out_dest", 32'(bus.m_axis_tdest), 32'(e.dest));
          if (e.chk_err) check("err_on_beat", 32'(err), 32'(e.err));
        end
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      sv_data    = bus.m_axis_tdata;
      sv_last    = bus.m_axis_tlast;
      sv_dest    = bus.m_axis_tdest;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    check("rst_m_tdata",  32'(bus.m_axis_tdata),  32'd0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_s_tready", 32'(bus.s_axis_tready), 32'd0);

    // Single channel, 4-beat packet on ch2.
    push_pkt(2, 8'hA0, 4);
    send_pkt(2, 8'hA0, 4);
    wait_drain("single");
    check("single_pkt_count", pkt_count, 32'd1);

    // Round-robin from reset: all four request together, grant order 0,1,2,3.
    do_reset();
    push_pkt(0, 8'h10, 2);
    push_pkt(1, 8'h20, 2);
    push_pkt(2, 8'h30, 2);
    push_pkt(3, 8'h40, 2);
    fork
      send_pkt(0, 8'h10, 2);
      send_pkt(1, 8'h20, 2);
      send_pkt(2, 8'h30, 2);
      send_pkt(3, 8'h40, 2);
    join
    wait_drain("rr");
    check("rr_pkt_count", pkt_count, 32'd4);

    // Backpressure: downstream ready toggles every cycle mid-packet.
    push_pkt(1, 8'hB0, 6);
    fork
      send_pkt(1, 8'hB0, 6);
      begin
        repeat (14) begin
          @(posedge clk);
          #1;
          bus.m_axis_tready = !bus.m_axis_tready;
        end
        bus.m_axis_tready = 1'b1;
      end
    join
    wait_drain("bp");
    check("bp_pkt_count", pkt_count, 32'd5);

    // Starvation: ch0 streams three packets, ch3 requests once during the first.
    push_pkt(0, 8'hC0, 2);
    push_pkt(3, 8'hD0, 2);
    push_pkt(0, 8'hC2, 2);
    push_pkt(0, 8'hC4, 2);
    fork
      begin
        send_pkt(0, 8'hC0, 2);
        send_pkt(0, 8'hC2, 2);
        send_pkt(0, 8'hC4, 2);
      end
      begin
        @(posedge clk);
        #1;
        send_pkt(3, 8'hD0, 2);
      end
    join
    wait_drain("starve");
    check("starve_pkt_count", pkt_count, 32'd9);

    // Overlength with MAX_PKT_LEN=8: 10 beats without tlast, then tlast.
    check("pre_ovl_err", 32'(err), 32'd0);
    for (int k = 1; k <= 11; k++)
      push_beat(2, 8'hE0 + 8'(k - 1), (k == 11), 1'b1, (k >= 8));
    for (int k = 1; k <= 11; k++)
      send_beat(2, 8'hE0 + 8'(k - 1), (k == 11));
    bus.s_axis_tvalid[2] = 1'b0;
    bus.s_axis_tlast[2]  = 1'b0;
    wait_drain("ovl");
    check("ovl_err_sticky", 32'(err), 32'd1);
    check("ovl_pkt_count", pkt_count, 32'd10);

    // Reset on beat 3 of a 6-beat packet.
    push_beat(1, 8'hF0, 1'b0, 1'b0, 1'b0);
    push_beat(1, 8'hF1, 1'b0, 1'b0, 1'b0);
    send_beat(1, 8'hF0, 1'b0);
    send_beat(1, 8'hF1, 1'b0);
    bus.s_axis_tvalid[1]         = 1'b1;
    bus.s_axis_tdata[1*DW +: DW] = 8'hF2;
    bus.s_axis_tlast[1]          = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_mid_s_tready", 32'(bus.s_axis_tready), 32'd0);
    bus.s_axis_tvalid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_pkt_count", pkt_count, 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_q_empty", 32'(q.size()), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_pkt(1, 8'h60, 3);
    send_pkt(1, 8'h60, 3);
    wait_drain("post_rst");
    check("post_rst_pkt_count", pkt_count, 32'd1);
    check("post_rst_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
